// File: rtl/fpu_pkg.sv
// Shared types for the floating-point add/subtract unit: rounding modes,
// sequencer states and flag bit positions.
package fpu_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RTZ = 2'b01,
        RND_RUP = 2'b10,
        RND_RDN = 2'b11
    } rnd_mode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_SPECIAL,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_DONE
    } state_t;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = CW'(WIDTH);
        // Scan upward so the highest set bit wins.
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle parametrised IEEE-754-style adder/subtractor. One stage per
// state; special operands bypass straight to DONE.
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [EXP_W+MAN_W:0] din1,
    input  logic [EXP_W+MAN_W:0] din2,
    input  logic                 op,
    input  logic [1:0]           rnd_mode,
    output logic                 busy,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags,
    output logic                 ready
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_W + 1;          // one spare bit for carry into overflow
    localparam int CW = $clog2(SW + 1);
    localparam int NW = EW + CW;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    state_t             state;
    logic [W-1:0]       a_reg, b_reg;
    logic               op_reg;
    rnd_mode_t          rnd_reg;
    logic               big_s_reg, sml_s_reg;
    logic [EXP_W-1:0]   big_e_reg, sml_e_reg;
    logic [MAN_W-1:0]   big_f_reg, sml_f_reg;
    logic [SW-1:0]      big_m_reg, sml_m_reg, nrm_m_reg;
    logic [SW:0]        sum_reg;
    logic [EW-1:0]      exp_reg;
    logic               sgn_reg, sub_reg, inex_reg;
    logic [MAN_W:0]     sig_reg;
    logic [W-1:0]       res_reg;
    logic [3:0]         flg_reg;

    // Unpack: order operands by magnitude so the subtraction never goes negative.
    logic b_sgn_eff, a_ge;
    assign b_sgn_eff = b_reg[W-1] ^ op_reg;
    assign a_ge      = a_reg[W-2:0] >= b_reg[W-2:0];

    logic big_nan, sml_nan, big_inf, sml_inf, big_zero, sml_zero, any_snan;
    assign big_nan  = (big_e_reg == EXP_ONES) && (big_f_reg != '0);
    assign sml_nan  = (sml_e_reg == EXP_ONES) && (sml_f_reg != '0);
    assign big_inf  = (big_e_reg == EXP_ONES) && (big_f_reg == '0);
    assign sml_inf  = (sml_e_reg == EXP_ONES) && (sml_f_reg == '0);
    assign big_zero = (big_e_reg == '0) && (big_f_reg == '0);
    assign sml_zero = (sml_e_reg == '0) && (sml_f_reg == '0);
    assign any_snan = (big_nan && !big_f_reg[MAN_W-1]) || (sml_nan && !sml_f_reg[MAN_W-1]);

    logic           spc_hit;
    logic [W-1:0]   spc_res;
    logic [3:0]     spc_flg;
    always_comb begin
        spc_hit = 1'b1;
        spc_res = QNAN;
        spc_flg = '0;
        if (big_nan || sml_nan) begin
            spc_flg[FLAG_NV] = any_snan;
        end else if (big_inf && sml_inf && (big_s_reg != sml_s_reg)) begin
            spc_flg[FLAG_NV] = 1'b1;
        end else if (big_inf) begin
            spc_res = {big_s_reg, EXP_ONES, {MAN_W{1'b0}}};
        end else if (big_zero) begin
            spc_res = {(big_s_reg == sml_s_reg) ? big_s_reg : (rnd_reg == RND_RDN), {(W-1){1'b0}}};
        end else if (sml_zero) begin
            spc_res = {big_s_reg, big_e_reg, big_f_reg};
        end else begin
            spc_hit = 1'b0;
        end
    end

    logic [EXP_W-1:0] big_ee, sml_ee, shamt;
    logic [SW-1:0]    big_ext, sml_ext, sml_mask, sml_sh;
    assign big_ee  = (big_e_reg == '0) ? EXP_ONE : big_e_reg;
    assign sml_ee  = (sml_e_reg == '0) ? EXP_ONE : sml_e_reg;
    assign shamt   = big_ee - sml_ee;
    assign big_ext = {big_e_reg != '0, big_f_reg, 3'b000};
    assign sml_ext = {sml_e_reg != '0, sml_f_reg, 3'b000};

    always_comb begin
        sml_mask  = ~({SW{1'b1}} << shamt);
        sml_sh    = '0;
        sml_sh[0] = |sml_ext;
        if (32'(shamt) < SW) begin
            sml_sh    = sml_ext >> shamt;
            sml_sh[0] = sml_sh[0] | (|(sml_ext & sml_mask));
        end
    end

    logic [SW:0] sum_next;
    assign sum_next = sub_reg ? ({1'b0, big_m_reg} - {1'b0, sml_m_reg})
                              : ({1'b0, big_m_reg} + {1'b0, sml_m_reg});

    // Normalise: left shift is clamped so the exponent never drops below the subnormal floor.
    logic [CW-1:0] lz;
    logic [EW-1:0] exp_m1;
    logic [NW-1:0] lz_n, em_n, nsh;
    fpu_lzc #(.WIDTH(SW), .CW(CW)) u_lzc (
        .din   (sum_reg[SW-1:0]),
        .count (lz)
    );
    assign exp_m1 = exp_reg - EW'(1);
    assign lz_n   = NW'(lz);
    assign em_n   = NW'(exp_m1);
    assign nsh    = (lz_n < em_n) ? lz_n : em_n;

    logic [MAN_W:0]   rsig;
    logic             g_bit, rs_bit, inex_c, inc;
    logic [MAN_W+1:0] sig_sum;
    assign rsig   = nrm_m_reg[SW-1:3];
    assign g_bit  = nrm_m_reg[2];
    assign rs_bit = |nrm_m_reg[1:0];
    assign inex_c = g_bit | rs_bit;
    always_comb begin
        case (rnd_reg)
            RND_RNE: inc = g_bit & (rs_bit | rsig[0]);
            RND_RUP: inc = inex_c & ~sgn_reg;
            RND_RDN: inc = inex_c & sgn_reg;
            default: inc = 1'b0;
        endcase
    end
    assign sig_sum = {1'b0, rsig} + (MAN_W+2)'(inc);

    logic         ovf, to_inf;
    logic [W-1:0] pk_res;
    logic [3:0]   pk_flg;
    assign ovf    = exp_reg >= {1'b0, EXP_ONES};
    assign to_inf = (rnd_reg == RND_RNE) || (rnd_reg == RND_RUP && !sgn_reg)
                                         || (rnd_reg == RND_RDN && sgn_reg);
    always_comb begin
        pk_flg = '0;
        if (ovf) begin
            pk_res = to_inf ? {sgn_reg, EXP_ONES, {MAN_W{1'b0}}}
                            : {sgn_reg, EXP_ONES - EXP_ONE, {MAN_W{1'b1}}};
            pk_flg[FLAG_OF] = 1'b1;
            pk_flg[FLAG_NX] = 1'b1;
        end else begin
            pk_res = {sgn_reg, sig_reg[MAN_W] ? exp_reg[EXP_W-1:0] : {EXP_W{1'b0}}, sig_reg[MAN_W-1:0]};
            pk_flg[FLAG_NX] = inex_reg;
            pk_flg[FLAG_UF] = inex_reg & ~sig_reg[MAN_W];
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: if (valid) begin
                a_reg   <= din1;
                b_reg   <= din2;
                op_reg  <= op;
                rnd_reg <= rnd_mode_t'(rnd_mode);
            end
            ST_UNPACK: begin
                if (a_ge) begin
                    {big_s_reg, big_e_reg, big_f_reg} <= a_reg;
                    {sml_s_reg, sml_e_reg, sml_f_reg} <= {b_sgn_eff, b_reg[W-2:0]};
                end else begin
                    {big_s_reg, big_e_reg, big_f_reg} <= {b_sgn_eff, b_reg[W-2:0]};
                    {sml_s_reg, sml_e_reg, sml_f_reg} <= a_reg;
                end
            end
            ST_SPECIAL: begin
                res_reg <= spc_res;
                flg_reg <= spc_flg;
            end
            ST_ALIGN: begin
                big_m_reg <= big_ext;
                sml_m_reg <= sml_sh;
                exp_reg   <= {1'b0, big_ee};
                sgn_reg   <= big_s_reg;
                sub_reg   <= big_s_reg ^ sml_s_reg;
            end
            ST_ADD: begin
                sum_reg <= sum_next;
                if (sub_reg && (big_m_reg == sml_m_reg)) begin
                    sgn_reg <= (rnd_reg == RND_RDN);
                end
            end
            ST_NORM: begin
                if (sum_reg[SW]) begin
                    nrm_m_reg <= {sum_reg[SW:2], sum_reg[1] | sum_reg[0]};
                    exp_reg   <= exp_reg + EW'(1);
                end else begin
                    nrm_m_reg <= sum_reg[SW-1:0] << nsh;
                    exp_reg   <= exp_reg - nsh[EW-1:0];
                end
            end
            ST_ROUND: begin
                inex_reg <= inex_c;
                if (sig_sum[MAN_W+1]) begin
                    sig_reg <= sig_sum[MAN_W+1:1];
                    exp_reg <= exp_reg + EW'(1);
                end else begin
                    sig_reg <= sig_sum[MAN_W:0];
                end
            end
            ST_PACK: begin
                res_reg <= pk_res;
                flg_reg <= pk_flg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: if (valid) begin
                    busy  <= 1'b1;
                    state <= ST_UNPACK;
                end
                ST_UNPACK:  state <= ST_SPECIAL;
                ST_SPECIAL: state <= spc_hit ? ST_DONE : ST_ALIGN;
                ST_ALIGN:   state <= ST_ADD;
                ST_ADD:     state <= ST_NORM;
                ST_NORM:    state <= ST_ROUND;
                ST_ROUND:   state <= ST_PACK;
                ST_PACK:    state <= ST_DONE;
                ST_DONE: begin
                    result <= res_reg;
                    flags  <= flg_reg;
                    ready  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed bench for fpu_addsub_param: single precision and a half-precision instance.
module tb_fpu_addsub_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_sp = 1'b0, valid_hp = 1'b0;
    logic [31:0] din1_sp = '0, din2_sp = '0;
    logic [15:0] din1_hp = '0, din2_hp = '0;
    logic        op_in = 1'b0;
    logic [1:0]  rnd_in = 2'b00;
    logic        busy_sp, ready_sp, busy_hp, ready_hp;
    logic [31:0] result_sp;
    logic [15:0] result_hp;
    logic [3:0]  flags_sp, flags_hp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .reset(reset), .valid(valid_sp), .din1(din1_sp), .din2(din2_sp),
        .op(op_in), .rnd_mode(rnd_in), .busy(busy_sp), .result(result_sp),
        .flags(flags_sp), .ready(ready_sp)
    );

    fpu_addsub_param #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .reset(reset), .valid(valid_hp), .din1(din1_hp), .din2(din2_hp),
        .op(op_in), .rnd_mode(rnd_in), .busy(busy_hp), .result(result_hp),
        .flags(flags_hp), .ready(ready_hp)
    );

    task automatic run_op(input bit hp, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [1:0] rm,
                          output logic [31:0] res, output logic [3:0] flg, output int lat);
        @(negedge clk);
        din1_sp = a; din2_sp = b; din1_hp = a[15:0]; din2_hp = b[15:0];
        op_in = o; rnd_in = rm;
        if (hp) valid_hp = 1'b1; else valid_sp = 1'b1;
        @(posedge clk); #1;
        valid_sp = 1'b0; valid_hp = 1'b0;
        lat = -1; res = '0; flg = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (hp ? ready_hp : ready_sp) begin
                lat = c;
                res = hp ? {16'h0, result_hp} : result_sp;
                flg = hp ? flags_hp : flags_sp;
                break;
            end
        end
        $display("op hp=%0d a=%h b=%h op=%0d rnd=%0d -> res=%h flags=%b lat=%0d", hp, a, b, o, rm, res, flg, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_sp !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_sp); end
        checks++; if (ready_sp !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready_sp); end
        checks++; if (result_sp !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", result_sp); end
        checks++; if (flags_sp !== 4'h0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", flags_sp); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h40400000) begin failures++; $display("FAIL add_1p2 got=%h exp=40400000", r); end
        checks++; if (f !== 4'b0000) begin failures++; $display("FAIL add_1p2_flags got=%b exp=0000", f); end
        checks++; if (l != 8) begin failures++; $display("FAIL add_1p2_latency got=%0d exp=8", l); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(0, 32'h7F800000, 32'h7F800000, 1'b1, 2'b00, r, f, l);
        checks++; if (r !== 32'h7FC00000) begin failures++; $display("FAIL inf_m_inf got=%h exp=7fc00000", r); end
        checks++; if (f !== 4'b1000) begin failures++; $display("FAIL inf_m_inf_flags got=%b exp=1000", f); end
        checks++; if (l != 3) begin failures++; $display("FAIL inf_m_inf_latency got=%0d exp=3", l); end
        run_op(0, 32'h7F800001, 32'h3F800000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h7FC00000 || f !== 4'b1000) begin failures++; $display("FAIL snan got=%h/%b exp=7fc00000/1000", r, f); end
        run_op(0, 32'h3F800000, 32'h7FC00001, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h7FC00000 || f !== 4'b0000) begin failures++; $display("FAIL qnan got=%h/%b exp=7fc00000/0000", r, f); end
        run_op(0, 32'h00000000, 32'hBF800000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'hBF800000 || l != 3) begin failures++; $display("FAIL zero_plus_x got=%h lat=%0d exp=bf800000 lat=3", r, l); end
        run_op(0, 32'h80000000, 32'h80000000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL negzero_sum got=%h exp=80000000", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h7F800000) begin failures++; $display("FAIL ovf_rne got=%h exp=7f800000", r); end
        checks++; if (f !== 4'b0101) begin failures++; $display("FAIL ovf_rne_flags got=%b exp=0101", f); end
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, r, f, l);
        checks++; if (r !== 32'h7F7FFFFF) begin failures++; $display("FAIL ovf_rtz got=%h exp=7f7fffff", r); end
        checks++; if (f !== 4'b0101) begin failures++; $display("FAIL ovf_rtz_flags got=%b exp=0101", f); end
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b11, r, f, l);
        checks++; if (r !== 32'h7F7FFFFF) begin failures++; $display("FAIL ovf_rdn_pos got=%h exp=7f7fffff", r); end
        run_op(0, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b11, r, f, l);
        checks++; if (r !== 32'hFF800000) begin failures++; $display("FAIL ovf_rdn_neg got=%h exp=ff800000", r); end
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(0, 32'h3F800000, 32'h33800000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h3F800000 || f !== 4'b0001) begin failures++; $display("FAIL tie_rne got=%h/%b exp=3f800000/0001", r, f); end
        run_op(0, 32'h3F800000, 32'h33800000, 1'b0, 2'b10, r, f, l);
        checks++; if (r !== 32'h3F800001 || f !== 4'b0001) begin failures++; $display("FAIL tie_rup got=%h/%b exp=3f800001/0001", r, f); end
        run_op(0, 32'h3F800000, 32'h3F800000, 1'b1, 2'b00, r, f, l);
        checks++; if (r !== 32'h00000000 || f !== 4'b0000) begin failures++; $display("FAIL cancel_rne got=%h/%b exp=00000000/0000", r, f); end
        run_op(0, 32'h3F800000, 32'h3F800000, 1'b1, 2'b11, r, f, l);
        checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL cancel_rdn got=%h exp=80000000", r); end
        run_op(0, 32'h40400000, 32'h3F800000, 1'b1, 2'b00, r, f, l);
        checks++; if (r !== 32'h40000000 || l != 8) begin failures++; $display("FAIL sub_3m1 got=%h lat=%0d exp=40000000 lat=8", r, l); end
    endtask

    task automatic test_subnormal();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(0, 32'h00000001, 32'h00000001, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h00000002) begin failures++; $display("FAIL subn_add got=%h exp=00000002", r); end
        checks++; if (f !== 4'b0000) begin failures++; $display("FAIL subn_flags got=%b exp=0000", f); end
        run_op(0, 32'h00800000, 32'h00000001, 1'b1, 2'b00, r, f, l);
        checks++; if (r !== 32'h007FFFFF) begin failures++; $display("FAIL subn_borrow got=%h exp=007fffff", r); end
    endtask

    task automatic test_half();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(1, 32'h00003C00, 32'h00003C00, 1'b0, 2'b00, r, f, l);
        checks++; if (r[15:0] !== 16'h4000) begin failures++; $display("FAIL half_add got=%h exp=4000", r[15:0]); end
        checks++; if (f !== 4'b0000 || l != 8) begin failures++; $display("FAIL half_flags_lat got=%b/%0d exp=0000/8", f, l); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic [3:0] f; int l; int rdy;
        @(negedge clk);
        din1_sp = 32'h3F800000; din2_sp = 32'h40000000; op_in = 1'b0; rnd_in = 2'b00; valid_sp = 1'b1;
        @(posedge clk); #1; valid_sp = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0; #1;
        checks++; if (busy_sp !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_sp); end
        checks++; if (result_sp !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=0", result_sp); end
        @(posedge clk); @(negedge clk); reset = 1'b1;
        rdy = 0;
        repeat (12) begin @(posedge clk); #1; if (ready_sp) rdy++; end
        checks++; if (rdy != 0) begin failures++; $display("FAIL abort_ready got=%0d exp=0", rdy); end
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00, r, f, l);
        checks++; if (r !== 32'h40400000 || l != 8) begin failures++; $display("FAIL after_abort got=%h lat=%0d exp=40400000 lat=8", r, l); end
    endtask

    task automatic test_back_to_back();
        int rdy; logic [31:0] r;
        @(negedge clk);
        din1_sp = 32'h3F800000; din2_sp = 32'h40000000; op_in = 1'b0; rnd_in = 2'b00; valid_sp = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy_sp !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy_sp); end
        din1_sp = 32'h40000000; din2_sp = 32'h40000000;
        repeat (4) @(posedge clk);
        #1; valid_sp = 1'b0;
        rdy = 0; r = '0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ready_sp) begin rdy++; r = result_sp; end
        end
        $display("op b2b pulses=%0d res=%h", rdy, r);
        checks++; if (rdy != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", rdy); end
        checks++; if (r !== 32'h40400000) begin failures++; $display("FAIL b2b_result got=%h exp=40400000", r); end
        checks++; if (result_sp !== 32'h40400000 || busy_sp !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%h/%b exp=40400000/0", result_sp, busy_sp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_overflow();
        test_rounding();
        test_subnormal();
        test_half();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_param.md
FPU_ADDSUB_PARAM -- requirements
Module: fpu_addsub_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 7..52); operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid  input  1  request; sampled only while busy=0.
REQ-006 SHALL have ports din1, din2  input  W  IEEE-754-style operands.
REQ-007 SHALL have port op  input  1  0 = din1+din2, 1 = din1-din2 (din2 sign inverted).
REQ-008 SHALL have port rnd_mode  input  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
REQ-009 SHALL have port busy  output  1  high from the acceptance edge until the ready pulse.
REQ-010 SHALL have port result  output  W  result, held stable until the next ready pulse.
REQ-011 SHALL have port flags  output  4  {NV, OF, UF, NX}, updated with result.
REQ-012 SHALL have port ready  output  1  single-cycle pulse marking result/flags valid.

Function
REQ-013 SHALL capture din1, din2, op and rnd_mode on the edge where valid=1 and busy=0; valid while busy=1 SHALL be ignored, not queued.
REQ-014 SHALL implement states IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE, one cycle each; DONE drives ready=1 and returns to IDLE.
REQ-015 SHALL assert ready exactly 8 cycles after acceptance on the normal path; SPECIAL SHALL branch straight to DONE for NaN/inf/zero-operand cases, giving 3 cycles.
REQ-016 ALIGN SHALL shift the smaller-exponent significand in one cycle (barrel shift), OR-ing shifted-out bits into sticky; shift amounts >= MAN_W+4 SHALL leave only sticky.
REQ-017 Subnormal inputs SHALL use exponent 1-bias with hidden bit 0; subnormal results SHALL be produced, never flushed to zero.
REQ-018 NORM SHALL, in one cycle, left-shift by leading-zero count, clamped so exponent is not below 1-bias, or right-shift by 1 on carry-out, preserving guard/round/sticky.
REQ-019 ROUND SHALL apply rnd_mode to guard/round/sticky; mantissa carry-out SHALL increment the exponent.
REQ-020 Overflow SHALL set OF and NX; result is inf for RNE, max-finite for RTZ, and for RUP/RDN inf only when rounding is toward the result's sign, else signed max-finite.
REQ-021 Any NaN input or inf-inf of effective opposite sign SHALL give canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0); NV set only for signalling NaN input or inf-inf.
REQ-022 Exact zero sum of opposite-sign operands SHALL be +0, except -0 under RDN; zero plus zero of equal sign keeps that sign.
REQ-023 UF SHALL be set when the result is tiny after rounding and inexact; NX whenever any discarded bit is nonzero.
REQ-024 Result and flags SHALL change only on the ready edge.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, busy=0, ready=0, result=0, flags=0, aborting any operation in flight without a ready pulse.
REQ-026 The first valid after reset release SHALL be accepted normally.

Structure
REQ-027 Package fpu_pkg SHALL hold the rnd_mode enum, state enum, and flag bit-index constants.
REQ-028 Sub-module fpu_lzc (parametrised leading-zero counter, combinational) SHALL be instantiated for NORM.

Verification
REQ-029 1.0+2.0: 0x3F800000, 0x40000000, op=0, RNE -> 0x40400000, flags 0, ready exactly 8 cycles after acceptance.
REQ-030 +inf minus +inf, op=1 -> 0x7FC00000, NV=1, ready 3 cycles after acceptance.
REQ-031 0x7F7FFFFF+0x7F7FFFFF -> RNE 0x7F800000, RTZ 0x7F7FFFFF, both OF=1, NX=1.
REQ-032 1.0+0x33800000 (2^-24) -> RNE 0x3F800000 NX=1; RUP 0x3F800001; 1.0-1.0 -> RNE 0x00000000, RDN 0x80000000.
REQ-033 0x00000001+0x00000001 -> 0x00000002 flags 0; with EXP_W=5, MAN_W=10, 0x3C00+0x3C00 -> 0x4000.
REQ-034 Assert reset during ALIGN -> no ready pulse, busy=0 next cycle; the following valid completes correctly; valid pulsed while busy -> no extra result.
